bar_reg_loader: RTL and testbench
=================================

Name: bar_reg_loader

Overview:
- Configuration controller for the bar-graph VGA display; owns the N bar-height registers the pixel pipeline compares against.
- Receives 16-bit SPI write packets from the external host on GPIO pins and oversamples them in the CLOCK_50 domain (no SPI-clock-domain logic).
- Validates each packet and writes it into a shadow bank.
- Commits the shadow bank to the active bank only at frame start, so bars never tear mid-frame.

Parameters:
- N, 15, number of bars / registers
- PKT_BITS, 16, bits per packet; {value[15:8], addr[7:0]}
- ERR_W, 8, width of saturating error counter

Ports:
- CLOCK_50  input  1  system clock, 50 MHz
- reset  input  1  asynchronous, active-high reset
- spi_sclk  input  1  host SPI clock, asynchronous to CLOCK_50, max CLOCK_50/8
- spi_cs  input  1  frame select, active-high; high while a packet is shifted
- spi_mosi  input  1  serial data, LSB first
- frame_start  input  1  one-cycle pulse from VGA timing at start of vertical sync
- bar_heights  output  N*8  active bank; bar i at bits [8i+7:8i]
- pkt_ok  output  1  one-cycle pulse: valid packet written to shadow
- pkt_err  output  1  one-cycle pulse: packet rejected
- err_count  output  ERR_W  saturating count of rejected packets
- pending  output  1  shadow differs from active (write since last commit)

Behaviour:
- Reset values (async, immediate): bar_heights=0, shadow=0, pkt_ok=0, pkt_err=0, err_count=0, pending=0, FSM=WAIT_IDLE, bit_cnt=0, shift=0, synchronizers=0.
- Input synchronization:
  - spi_sclk, spi_cs, spi_mosi each pass through 2 flops, then a third delay flop for edge detection.
  - All decisions use synchronized values only.
- Shift rule: on each detected sclk rising edge while in SHIFT, shift={mosi_sync, shift[15:1]} and bit_cnt++.
  - bit_cnt saturates at 17, i.e. any count above 16 is recorded as overrun.
  - The first bit received lands in bit 0 after 16 shifts.
- FSM:
  - WAIT_IDLE: stay until cs_sync=0, then go to IDLE. Guards against reset being released mid-packet.
  - IDLE: on cs rising edge, clear bit_cnt and shift, go to SHIFT.
  - SHIFT: on cs falling edge, go to CHECK. An sclk edge in the same cycle as the cs fall is ignored.
  - CHECK (1 cycle):
    - If bit_cnt==16 and shift[7:0]<N: shadow[addr]=shift[15:8], pending=1, pkt_ok=1.
    - Otherwise: pkt_err=1 and err_count++, saturating at all-ones.
    - Always return to IDLE.
- Latency: pkt_ok and the shadow update become visible 4 CLOCK_50 edges after the cs falling edge is first sampled (2 sync + edge detect + CHECK).
- Commit:
  - On frame_start with pending=1: bar_heights<=shadow (all N at once), pending<=0.
  - frame_start with pending=0: no effect.
- Simultaneous CHECK write and frame_start:
  - The commit copies the shadow contents from before this cycle.
  - The new write lands in shadow, and pending ends at 1, so it is committed at the next frame.
- Address boundary: addr N-1 is accepted; addr N through 255 are rejected.
- Repeated writes to the same address before a commit: the last value wins.
- Reset mid-packet: all state cleared; a cs still high after reset produces neither pkt_ok nor pkt_err.
- bar_heights changes only on a reset or a commit cycle.

Decomposition:
- Shared package bar_pkg holds:
  - N_BARS, PKT_BITS, ADDR_W=8, VAL_W=8
  - typedef bar_bank_t = logic [N_BARS-1:0][7:0]
  - enum loader_state_t {WAIT_IDLE, IDLE, SHIFT, CHECK}
- The VGA renderer imports the same bank type.
- One natural sub-module, sync_edge: 2-flop synchronizer plus rise/fall pulse outputs.
  - Instantiated for sclk and cs.
  - mosi uses only the synchronizer path.

Test Plan:
- Reset, then send packet addr=3 val=0xA5 (16 sclk), drop cs -> pkt_ok pulses once, pending=1, bar_heights unchanged; after frame_start, bar 3 reads 0xA5, pending=0, others 0.
- Send addr=15 (=N) val=0x10 -> pkt_err pulse, err_count=1, shadow and pending unchanged; addr=14 val=0x10 -> accepted.
- Send 15 bits, then 17 bits -> two pkt_err pulses, err_count=2; 300 bad packets -> err_count saturates at 255.
- Assert frame_start in the exact CHECK cycle of a write addr=0 val=0x42 -> bar 0 still old after that commit, pending=1; next frame_start -> bar 0=0x42.
- Assert reset after 8 bits with cs held high, release reset, finish 8 bits, drop cs -> no pkt_ok/pkt_err; the following full packet is accepted normally.
- Two writes addr=5 (0x11, then 0x22) before one frame_start -> bar 5=0x22 after commit.

Source files
------------

// File: rtl/bar_pkg.sv
// Shared definitions for the bar-graph display: register bank type, packet
// geometry and the loader state encoding. The VGA renderer imports the same
// bank type so both sides agree on the bar layout.
package bar_pkg;

    localparam int N_BARS   = 15;  // number of bars / height registers
    localparam int ADDR_W   = 8;   // packet address field width
    localparam int VAL_W    = 8;   // packet value field width
    localparam int PKT_BITS = ADDR_W + VAL_W;

    // Bar i occupies bits [8i+7:8i] when the bank is flattened.
    typedef logic [N_BARS-1:0][VAL_W-1:0] bar_bank_t;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        CHECK     = 2'd3
    } loader_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with an extra delay flop for edge detection.
//   clk  : sampling clock
//   rst  : asynchronous active-high reset, clears all flops
//   din  : asynchronous input
//   dout : synchronized level
//   rise : one-cycle pulse on a synchronized 0->1 transition
//   fall : one-cycle pulse on a synchronized 1->0 transition
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic dly;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            dly  <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            dly  <= sync;
        end
    end

    assign dout = sync;
    assign rise = sync & ~dly;
    assign fall = ~sync & dly;

endmodule

// File: rtl/bar_reg_loader.sv
// Configuration controller for the bar-graph VGA display.
// SPI write packets {value[15:8], addr[7:0]}, LSB first, are oversampled in
// the CLOCK_50 domain, validated, written into a shadow bank, and the shadow
// bank is copied to the active bank only on frame_start so bars never tear.
//   CLOCK_50    : system clock
//   reset       : asynchronous active-high reset
//   spi_sclk    : host SPI clock (async, <= CLOCK_50/8)
//   spi_cs      : packet frame, active-high
//   spi_mosi    : serial data, LSB first
//   frame_start : one-cycle pulse at start of vertical sync
//   bar_heights : active bank, bar i at [8i+7:8i]
//   pkt_ok      : pulse, valid packet written to shadow
//   pkt_err     : pulse, packet rejected
//   err_count   : saturating count of rejected packets
//   pending     : shadow holds writes not yet committed
//
// state     | meaning
// ----------+-------------------------------------------------------------
// WAIT_IDLE | after reset; wait for synchronizers to fill and cs to be low
// IDLE      | waiting for cs rising edge
// SHIFT     | shifting mosi on each sclk rising edge until cs falls
// CHECK     | one cycle: validate packet, write shadow or count error
module bar_reg_loader #(
    parameter int N        = bar_pkg::N_BARS,
    parameter int PKT_BITS = bar_pkg::PKT_BITS,
    parameter int ERR_W    = 8
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             spi_sclk,
    input  logic             spi_cs,
    input  logic             spi_mosi,
    input  logic             frame_start,
    output logic [N*8-1:0]   bar_heights,
    output logic             pkt_ok,
    output logic             pkt_err,
    output logic [ERR_W-1:0] err_count,
    output logic             pending
);

    import bar_pkg::*;

    localparam int CNT_W   = $clog2(PKT_BITS + 2);
    localparam int CNT_SAT = PKT_BITS + 1;   // any count above PKT_BITS is overrun

    typedef logic [N-1:0][VAL_W-1:0] bank_t;

    // ---------------------------------------------------------------
    // Input synchronization
    // ---------------------------------------------------------------
    logic cs_sync, cs_rise, cs_fall;
    logic sclk_rise, sclk_sync_unused, sclk_fall_unused;
    logic mosi_meta, mosi_sync;

    sync_edge u_sync_cs (
        .clk  (CLOCK_50),
        .rst  (reset),
        .din  (spi_cs),
        .dout (cs_sync),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    sync_edge u_sync_sclk (
        .clk  (CLOCK_50),
        .rst  (reset),
        .din  (spi_sclk),
        .dout (sclk_sync_unused),
        .rise (sclk_rise),
        .fall (sclk_fall_unused)
    );

    // mosi needs only the level; its 2-flop latency matches sclk_rise timing.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            mosi_meta <= spi_mosi;
            mosi_sync <= mosi_meta;
        end
    end

    // ---------------------------------------------------------------
    // Post-reset settle timer. The synchronizers reset to 0, so cs_sync
    // reads low for two cycles even if the pin is high. Leaving WAIT_IDLE
    // before they hold real samples would turn a packet in flight at
    // reset into a spurious cs rise.
    // ---------------------------------------------------------------
    logic [1:0] warm_cnt;
    logic       warm_done;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            warm_cnt <= 2'd2;
        end else if (warm_cnt != 2'd0) begin
            warm_cnt <= warm_cnt - 2'd1;
        end
    end

    assign warm_done = (warm_cnt == 2'd0);

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    loader_state_t state, state_nxt;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= WAIT_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT_IDLE: if (warm_done && !cs_sync) state_nxt = IDLE;
            IDLE:      if (cs_rise)               state_nxt = SHIFT;
            SHIFT:     if (cs_fall)               state_nxt = CHECK;
            CHECK:                                state_nxt = IDLE;
            default:                              state_nxt = WAIT_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: output decode
    // ---------------------------------------------------------------
    logic clr_shift, do_shift, do_check;

    always_comb begin
        clr_shift = 1'b0;
        do_shift  = 1'b0;
        do_check  = 1'b0;
        unique case (state)
            IDLE:    clr_shift = cs_rise;
            // An sclk edge coincident with the cs fall belongs to no packet.
            SHIFT:   do_shift  = sclk_rise & ~cs_fall;
            CHECK:   do_check  = 1'b1;
            default: ;
        endcase
    end

    // ---------------------------------------------------------------
    // Shift register and bit counter
    // ---------------------------------------------------------------
    logic [CNT_W-1:0]    bit_cnt;
    logic [PKT_BITS-1:0] shift_q;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
            shift_q <= '0;
        end else if (clr_shift) begin
            bit_cnt <= '0;
            shift_q <= '0;
        end else if (do_shift) begin
            shift_q <= {mosi_sync, shift_q[PKT_BITS-1:1]};
            if (bit_cnt != CNT_W'(CNT_SAT)) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------
    // Packet validation
    // ---------------------------------------------------------------
    logic [ADDR_W-1:0] pkt_addr;
    logic [VAL_W-1:0]  pkt_val;
    logic              pkt_good;
    logic              do_write;

    assign pkt_addr = shift_q[ADDR_W-1:0];
    assign pkt_val  = shift_q[PKT_BITS-1:ADDR_W];
    assign pkt_good = (bit_cnt == CNT_W'(PKT_BITS)) && (32'(pkt_addr) < 32'(N));
    assign do_write = do_check & pkt_good;

    // ---------------------------------------------------------------
    // Shadow / active banks. A commit and a write in the same cycle both
    // happen: the commit takes the pre-write shadow, and pending stays set
    // so the new value goes out on the next frame.
    // ---------------------------------------------------------------
    bank_t shadow;
    bank_t active;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (do_write && pkt_addr == ADDR_W'(i)) begin
                    shadow[i] <= pkt_val;
                end
            end
            if (frame_start && pending) begin
                active <= shadow;
            end
            if (do_write) begin
                pending <= 1'b1;
            end else if (frame_start) begin
                pending <= 1'b0;
            end
        end
    end

    assign bar_heights = active;

    // ---------------------------------------------------------------
    // Status pulses and error counter
    // ---------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pkt_ok    <= 1'b0;
            pkt_err   <= 1'b0;
            err_count <= '0;
        end else begin
            pkt_ok  <= do_write;
            pkt_err <= do_check & ~pkt_good;
            if (do_check && !pkt_good && err_count != '1) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bar_reg_loader.sv
module tb_bar_reg_loader;

    localparam int NB = 15;

    logic            CLOCK_50    = 1'b0;
    logic            reset       = 1'b1;
    logic            spi_sclk    = 1'b0;
    logic            spi_cs      = 1'b0;
    logic            spi_mosi    = 1'b0;
    logic            frame_start = 1'b0;
    logic [NB*8-1:0] bar_heights;
    logic            pkt_ok;
    logic            pkt_err;
    logic [7:0]      err_count;
    logic            pending;

    always #10 CLOCK_50 = ~CLOCK_50;

    bar_reg_loader dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .spi_sclk    (spi_sclk),
        .spi_cs      (spi_cs),
        .spi_mosi    (spi_mosi),
        .frame_start (frame_start),
        .bar_heights (bar_heights),
        .pkt_ok      (pkt_ok),
        .pkt_err     (pkt_err),
        .err_count   (err_count),
        .pending     (pending)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       ok;
        logic [7:0] err;
    } exp_t;

    exp_t expq[$];

    // Reference model: register file semantics only.
    logic [7:0] m_shadow [NB];
    logic [7:0] m_active [NB];
    bit         m_pending;
    int         m_err;
    bit         m_last_ok;

    function automatic logic [NB*8-1:0] pack_active();
        logic [NB*8-1:0] v;
        for (int i = 0; i < NB; i++) v[8*i +: 8] = m_active[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NB; i++) begin
            m_shadow[i] = 8'h00;
            m_active[i] = 8'h00;
        end
        m_pending = 1'b0;
        m_err     = 0;
        expq.delete();
    endtask

    task automatic model_pkt(input logic [31:0] d, input int nbits);
        exp_t e;
        int   addr;
        addr      = int'(d[7:0]);
        m_last_ok = (nbits == 16) && (addr < NB);
        if (m_last_ok) begin
            m_shadow[addr] = d[15:8];
            m_pending      = 1'b1;
        end else if (m_err < 255) begin
            m_err++;
        end
        e.ok  = m_last_ok;
        e.err = 8'(m_err);
        expq.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every status pulse, and holds the
    // active bank to the model on every cycle.
    always @(negedge CLOCK_50) begin
        if (!reset) begin
            chk("bar_heights", bar_heights, pack_active());
            if (pkt_ok || pkt_err) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse actual ok=%0b err=%0b required=none", pkt_ok, pkt_err);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("pulse_kind", {pkt_ok, pkt_err}, {e.ok, ~e.ok});
                    chk("err_count", err_count, e.err);
                end
            end
        end
    end

    task automatic cs_raise();
        @(negedge CLOCK_50);
        spi_cs = 1'b1;
        repeat (4) @(negedge CLOCK_50);
    endtask

    task automatic shift_bits(input logic [31:0] d, input int from, input int n);
        for (int i = from; i < from + n; i++) begin
            @(negedge CLOCK_50);
            spi_mosi = d[i];
            repeat (4) @(negedge CLOCK_50);
            spi_sclk = 1'b1;
            repeat (5) @(negedge CLOCK_50);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic finish_pkt(input logic [31:0] d, input int nbits,
                              input bit frame_at_check, input bit expect_resp);
        logic [7:0] old_sh [NB];
        bit         old_pend;
        repeat (6) @(negedge CLOCK_50);
        old_sh   = m_shadow;
        old_pend = m_pending;
        m_last_ok = 1'b0;
        if (expect_resp) model_pkt(d, nbits);
        spi_cs = 1'b0;
        if (frame_at_check) begin
            // cs fall sampled, synchronized, edge-detected: CHECK is the 4th edge.
            repeat (3) @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            frame_start = 1'b1;
            @(posedge CLOCK_50);
            #1 frame_start = 1'b0;
            if (old_pend) begin
                m_active  = old_sh;
                m_pending = m_last_ok;
            end
        end
        for (int k = 0; k < 40 && expq.size() != 0; k++) @(negedge CLOCK_50);
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL response_timeout actual outstanding=%0d required=0", expq.size());
            expq.delete();
        end
        repeat (3) @(negedge CLOCK_50);
    endtask

    task automatic send_pkt(input logic [31:0] d, input int nbits, input bit frame_at_check);
        cs_raise();
        shift_bits(d, 0, nbits);
        finish_pkt(d, nbits, frame_at_check, 1'b1);
    endtask

    task automatic do_frame();
        @(negedge CLOCK_50);
        chk("pending_pre_frame", pending, m_pending);
        frame_start = 1'b1;
        @(posedge CLOCK_50);
        #1 frame_start = 1'b0;
        if (m_pending) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end
        @(negedge CLOCK_50);
        chk("pending_post_frame", pending, m_pending);
        chk("commit_bank", bar_heights, pack_active());
    endtask

    initial begin
        logic [31:0] d;
        int          nb;
        model_clear();

        repeat (3) @(negedge CLOCK_50);
        chk("rst_bar_heights", bar_heights, '0);
        chk("rst_pkt_ok", pkt_ok, 1'b0);
        chk("rst_pkt_err", pkt_err, 1'b0);
        chk("rst_err_count", err_count, 8'h00);
        chk("rst_pending", pending, 1'b0);
        reset = 1'b0;
        repeat (5) @(negedge CLOCK_50);

        // Basic write then commit.
        send_pkt(32'h0000_A503, 16, 1'b0);
        chk("pending_after_write", pending, 1'b1);
        chk("bank_before_commit", bar_heights, '0);
        do_frame();
        chk("bar3_committed", bar_heights[31:24], 8'hA5);

        // Address boundary.
        send_pkt(32'h0000_100F, 16, 1'b0);
        chk("pending_after_bad_addr", pending, m_pending);
        send_pkt(32'h0000_100E, 16, 1'b0);
        chk("pending_after_addr14", pending, 1'b1);

        // Bit-count errors: short and overrun.
        send_pkt(32'h0000_1102, 15, 1'b0);
        send_pkt(32'h0001_1102, 17, 1'b0);
        chk("err_after_len_errs", err_count, 8'(m_err));

        // Commit coinciding with CHECK.
        send_pkt(32'h0000_0700, 16, 1'b0);
        send_pkt(32'h0000_4200, 16, 1'b1);
        chk("sim_bar0_old", bar_heights[7:0], 8'h07);
        chk("sim_pending", pending, 1'b1);
        do_frame();
        chk("sim_bar0_new", bar_heights[7:0], 8'h42);

        // Last write wins.
        send_pkt(32'h0000_1105, 16, 1'b0);
        send_pkt(32'h0000_2205, 16, 1'b0);
        do_frame();
        chk("bar5_last_wins", bar_heights[47:40], 8'h22);

        // Reset with a packet in flight.
        d = 32'h0000_3C09;
        cs_raise();
        shift_bits(d, 0, 8);
        @(negedge CLOCK_50);
        reset = 1'b1;
        model_clear();
        repeat (3) @(negedge CLOCK_50);
        chk("midrst_bank", bar_heights, '0);
        reset = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        shift_bits(d, 8, 8);
        finish_pkt(d, 16, 1'b0, 1'b0);
        chk("midrst_err_count", err_count, 8'h00);
        chk("midrst_pending", pending, 1'b0);
        send_pkt(32'h0000_5C09, 16, 1'b0);
        do_frame();
        chk("post_rst_bar9", bar_heights[79:72], 8'h5C);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            d  = $urandom;
            d[7:0] = 8'($urandom_range(0, 20));
            nb = ($urandom_range(0, 9) < 7) ? 16 : int'($urandom_range(0, 20));
            send_pkt(d, nb, $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 9) < 3) do_frame();
        end
        do_frame();

        // Error counter saturation.
        for (int n = 0; n < 300; n++) begin
            d = $urandom;
            send_pkt(d, int'($urandom_range(0, 3)), 1'b0);
        end
        chk("err_saturated", err_count, 8'hFF);
        send_pkt(32'h0000_0000, 2, 1'b0);
        chk("err_stays_sat", err_count, 8'hFF);

        do_frame();
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", expq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
